// File: rtl/receiver_queue.sv
// rtl/receiver_queue.sv - per-source receive queues behind a registered address filter
module receiver_queue #(
  parameter int ID_WIDTH   = 2,
  parameter int DATA_WIDTH = 8,
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int DROP_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [2*ID_WIDTH+DATA_WIDTH-1:0] rx_in,
  input  logic                             rx_valid,
  input  logic [ID_WIDTH-1:0]              id,
  input  logic [ID_WIDTH-1:0]              rx_addr,
  input  logic                             rd_en,
  input  logic                             ovf_clr,
  output logic [WIDTH-1:0]                 flag_res,
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic [$clog2(DEPTH):0]           level,
  output logic                             overflow,
  output logic [DROP_WIDTH-1:0]            drop_count
);

  localparam int NSRC = 1 << ID_WIDTH;
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int PW   = 2 * ID_WIDTH + DATA_WIDTH;

  localparam logic [CW-1:0]       FULL_CNT  = CW'(DEPTH);
  localparam logic [ID_WIDTH-1:0] BCAST_ID  = {ID_WIDTH{1'b1}};
  localparam logic [DROP_WIDTH-1:0] DROP_MAX = {DROP_WIDTH{1'b1}};

  // Stage-1 copy of the incoming packet; every decision below uses it.
  logic          st_vld_q;
  logic [PW-1:0] st_pkt_q;

  // Per-source queue state.
  logic [AW-1:0]         wptr_q [NSRC];
  logic [AW-1:0]         wptr_d [NSRC];
  logic [AW-1:0]         rptr_q [NSRC];
  logic [AW-1:0]         rptr_d [NSRC];
  logic [CW-1:0]         cnt_q  [NSRC];
  logic [CW-1:0]         cnt_d  [NSRC];
  logic [NSRC-1:0]       ovf_q;
  logic [NSRC-1:0]       ovf_d;
  logic [DROP_WIDTH-1:0] drop_q;
  logic [DROP_WIDTH-1:0] drop_d;

  // Payload storage is never reset; an empty queue masks data_out instead.
  logic [DATA_WIDTH-1:0] mem_q [NSRC][DEPTH];

  // Fields of the registered packet: {src, data, dest}.
  logic [ID_WIDTH-1:0]   pkt_src;
  logic [ID_WIDTH-1:0]   pkt_dest;
  logic [DATA_WIDTH-1:0] pkt_data;

  assign pkt_dest = st_pkt_q[ID_WIDTH-1:0];
  assign pkt_data = st_pkt_q[ID_WIDTH +: DATA_WIDTH];
  assign pkt_src  = st_pkt_q[PW-1 -: ID_WIDTH];

  // Control decisions for this edge.
  logic            accept;
  logic            pop_sel;
  logic            pop_src;
  logic            src_full;
  logic            push;
  logic            drop;
  logic [NSRC-1:0] pop_vec;
  logic [NSRC-1:0] push_vec;
  logic [NSRC-1:0] drop_vec;
  logic [NSRC-1:0] clr_vec;

  // Filter, then resolve push/pop/drop; a pop of the same full queue makes room.
  always_comb begin
    accept   = st_vld_q && ((pkt_dest == id) || (pkt_dest == BCAST_ID));
    pop_sel  = rd_en && (cnt_q[rx_addr] != '0);
    pop_src  = pop_sel && (rx_addr == pkt_src);
    src_full = (cnt_q[pkt_src] == FULL_CNT);
    push     = accept && (!src_full || pop_src);
    drop     = accept && src_full && !pop_src;
    pop_vec  = pop_sel ? (NSRC'(1) << rx_addr) : '0;
    push_vec = push    ? (NSRC'(1) << pkt_src) : '0;
    drop_vec = drop    ? (NSRC'(1) << pkt_src) : '0;
    clr_vec  = ovf_clr ? (NSRC'(1) << rx_addr) : '0;
  end

  // Next-state for pointers, counts, sticky overflow and the drop counter.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      wptr_d[i] = wptr_q[i];
      rptr_d[i] = rptr_q[i];
      cnt_d[i]  = cnt_q[i];
    end
    ovf_d  = ovf_q;
    drop_d = drop_q;

    for (int i = 0; i < NSRC; i++) begin
      if (pop_vec[i]) begin
        rptr_d[i] = rptr_q[i] + 1'b1;
      end
      if (push_vec[i]) begin
        wptr_d[i] = wptr_q[i] + 1'b1;
      end
      case ({push_vec[i], pop_vec[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
        2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
        default: cnt_d[i] = cnt_q[i];
      endcase
      // A fresh overflow on the queue being cleared keeps the bit set.
      if (clr_vec[i]) begin
        ovf_d[i] = 1'b0;
      end
      if (drop_vec[i]) begin
        ovf_d[i] = 1'b1;
      end
    end

    if (drop && (drop_q != DROP_MAX)) begin
      drop_d = drop_q + 1'b1;
    end
  end

  // Stage-1 packet register; a packet caught here by reset is lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_vld_q <= 1'b0;
      st_pkt_q <= '0;
    end else begin
      st_vld_q <= rx_valid;
      st_pkt_q <= rx_in;
    end
  end

  // Queue bookkeeping registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NSRC; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      ovf_q  <= '0;
      drop_q <= '0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end

  // Payload write into the tail slot of the source's queue.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[pkt_src][wptr_q[pkt_src]] <= pkt_data;
    end
  end

  // Status and first-word-fall-through head of the selected queue.
  always_comb begin
    level      = cnt_q[rx_addr];
    flag_res   = {WIDTH{cnt_q[rx_addr] != '0}};
    data_out   = (cnt_q[rx_addr] != '0) ? mem_q[rx_addr][rptr_q[rx_addr]] : '0;
    overflow   = ovf_q[rx_addr];
    drop_count = drop_q;
  end

endmodule

// File: doc/receiver_queue.md
RECEIVER_QUEUE -- requirements
Module: receiver_queue

Interface
REQ-001 Parameter ID_WIDTH, default 2: node/source ID bits; NSRC = 2**ID_WIDTH source queues.
REQ-002 Parameter DATA_WIDTH, default 8: payload bits.
REQ-003 Parameter WIDTH, default 8: width of sign-extended flag_res.
REQ-004 Parameter DEPTH, default 4: entries per source queue; power of 2, >=2.
REQ-005 Parameter DROP_WIDTH, default 8: drop-counter width.
REQ-006 Ports (name direction width meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rx_in  in  2*ID_WIDTH+DATA_WIDTH  packet {src[MSBs], data, dest[LSBs]}.
- rx_valid  in  1  rx_in carries a packet this cycle.
- id  in  ID_WIDTH  this node's ID.
- rx_addr  in  ID_WIDTH  source queue selected for read/status.
- rd_en  in  1  pop head of selected queue.
- ovf_clr  in  1  clear sticky overflow of selected queue.
- flag_res  out  WIDTH  selected queue non-empty, sign-extended (all-ones/all-zeros).
- data_out  out  DATA_WIDTH  head of selected queue (first-word-fall-through).
- level  out  $clog2(DEPTH)+1  occupancy of selected queue.
- overflow  out  1  sticky overflow of selected queue.
- drop_count  out  DROP_WIDTH  total dropped packets, all sources.

Function
REQ-007 Stage 1: {rx_valid, rx_in} SHALL be registered every cycle; all decisions use the registered copy.
REQ-008 Accept: registered valid AND (dest == id OR dest == all-ones broadcast).
REQ-009 Accepted packet SHALL be pushed into queue[src]; data visible at data_out (when selected) on the second rising edge after presentation at rx_in.
REQ-010 Each queue: circular buffer, write/read pointers wrap at DEPTH, count 0..DEPTH.
REQ-011 Push to full queue with no same-cycle pop of that queue: packet dropped, overflow[src] set, drop_count incremented.
REQ-012 Full queue, push and pop same cycle: both performed, push accepted, count unchanged, no drop.
REQ-013 Empty queue, push and rd_en same cycle: pop ignored, push performed, count becomes 1.
REQ-014 Pop: rd_en=1 with selected queue non-empty advances its read pointer, count-1; rd_en on empty queue ignored, no state change.
REQ-015 Non-selected queues unaffected by rd_en/ovf_clr.
REQ-016 drop_count SHALL saturate at 2**DROP_WIDTH-1.
REQ-017 ovf_clr clears overflow[rx_addr]; a same-cycle new overflow on that queue wins (bit stays 1).
REQ-018 Outputs combinational from rx_addr and queue state: flag_res = {WIDTH{count!=0}}; data_out = head entry, or 0 when empty; level = count; overflow = overflow[rx_addr].
REQ-019 Non-matching or invalid packets SHALL leave all state unchanged and are not counted as drops.

Reset
REQ-020 rst low SHALL immediately (asynchronously) clear input register, all pointers, counts, overflow bits and drop_count; flag_res=0, data_out=0, level=0, overflow=0, drop_count=0.
REQ-021 A packet in stage 1 when rst asserts is lost; no push occurs on the deassertion edge.
REQ-022 Queue storage contents need not be reset; data_out is 0 whenever the selected queue is empty.

Verification (ID_WIDTH=2, DATA_WIDTH=8, WIDTH=8, DEPTH=4, id=1)
REQ-023 Unicast: rx_in={src=2,0xA5,dest=1}, rx_valid=1 one cycle, rx_addr=2 -> 2 edges later flag_res=0xFF, data_out=0xA5, level=1; rd_en 1 cycle -> flag_res=0x00, data_out=0x00, level=0.
REQ-024 Filter/broadcast: {src=0,0x11,dest=3} then {src=0,0x22,dest=2} -> queue0 holds only 0x11, level=1, drop_count=0.
REQ-025 Overflow: 5 packets src=3 data 1..5 to dest=1, no reads -> level=4, overflow=1, drop_count=1, reads return 1,2,3,4; ovf_clr -> overflow=0.
REQ-026 Full push+pop: queue3 full (1..4), packet 0x09 arrives at stage 2 on same edge as rd_en -> level=4, no drop, read order 2,3,4,9.
REQ-027 Saturation and reset: 300 drops -> drop_count=255; assert rst mid-stream between edges -> all outputs 0 before next clk edge, nothing pushed after release until new packet.
